// File: rtl/button_conditioner.sv
// Per-channel pushbutton conditioner: 2-flop synchroniser, counter debounce, and one-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int NBTN          = 2,
    parameter int DEBOUNCE_CYC  = 50000,
    parameter int REPEAT_DELAY  = 2500000,
    parameter int REPEAT_PERIOD = 500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release
);

    localparam int MAX_A   = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NBTN; g++) begin : g_ch
            logic             s1_q;
            logic             s2_q;
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             press_q, press_d;
            logic             rel_q, rel_d;
`ifdef BTN_AUTOREPEAT_EN
            // rpt_q counts cycles since the last press pulse; rpt_first_q selects delay vs period.
            localparam logic [CNT_W-1:0] RPT_DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] RPT_PER_M1 = CNT_W'(REPEAT_PERIOD - 1);
            logic [CNT_W-1:0] rpt_q, rpt_d;
            logic             rpt_first_q, rpt_first_d;
`endif

            // Synchroniser, FSM state and registered outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q        <= 1'b0;
                    s2_q        <= 1'b0;
                    state_q     <= S_LOW;
                    cnt_q       <= CNT_ZERO;
                    level_q     <= 1'b0;
                    press_q     <= 1'b0;
                    rel_q       <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_q       <= CNT_ZERO;
                    rpt_first_q <= 1'b1;
`endif
                end else begin
                    s1_q        <= btn_raw[g];
                    s2_q        <= s1_q;
                    state_q     <= state_d;
                    cnt_q       <= cnt_d;
                    level_q     <= level_d;
                    press_q     <= press_d;
                    rel_q       <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_q       <= rpt_d;
                    rpt_first_q <= rpt_first_d;
`endif
                end
            end

            // Debounce next-state and output decode.
            always_comb begin
                state_d     = state_q;
                cnt_d       = cnt_q;
                level_d     = level_q;
                press_d     = 1'b0;
                rel_d       = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_d       = rpt_q;
                rpt_first_d = rpt_first_q;
`endif
                case (state_q)
                    S_LOW: begin
                        if (s2_q) begin
                            state_d = S_RISE;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d   = CNT_ZERO;
                        end
                    end
                    S_RISE: begin
                        if (!s2_q) begin
                            state_d = S_LOW;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_q == DEB_LIM) begin
                            state_d = S_HIGH;
                            cnt_d   = CNT_ZERO;
                            level_d = 1'b1;
                            press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_d       = CNT_ZERO;
                            rpt_first_d = 1'b1;
`endif
                        end else begin
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end
                    S_HIGH: begin
                        if (!s2_q) begin
                            state_d = S_FALL;
                            cnt_d   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_d       = CNT_ZERO;
                            rpt_first_d = 1'b1;
`endif
                        end else begin
                            cnt_d   = CNT_ZERO;
`ifdef BTN_AUTOREPEAT_EN
                            if (rpt_q == (rpt_first_q ? RPT_DLY_M1 : RPT_PER_M1)) begin
                                press_d     = 1'b1;
                                rpt_d       = CNT_ZERO;
                                rpt_first_d = 1'b0;
                            end else begin
                                rpt_d       = sat_inc(rpt_q);
                            end
`endif
                        end
                    end
                    S_FALL: begin
                        if (s2_q) begin
                            state_d = S_HIGH;
                            cnt_d   = CNT_ZERO;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_d       = CNT_ZERO;
                            rpt_first_d = 1'b1;
`endif
                        end else if (cnt_q == DEB_LIM) begin
                            state_d = S_LOW;
                            cnt_d   = CNT_ZERO;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end
                    default: begin
                        state_d = S_LOW;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b0;
                    end
                endcase
            end

            assign btn_level[g]   = level_q;
            assign btn_press[g]   = press_q;
            assign btn_release[g] = rel_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Window index k counts clock edges after an input change; k=1 is the first edge that samples it.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    int total = 0;
    int bad   = 0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    button_conditioner #(
        .NBTN(2),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs n edges; channel i flips its level and pulses at edge at_i (0 = no event).
    task automatic window(input string tag, input int n, input int at0, input int at1,
                          input logic [1:0] lv0, input bit rising);
        logic [1:0] ep, er, el;
        int at [2];
        at[0] = at0;
        at[1] = at1;
        for (int k = 1; k <= n; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                ep[i] = rising && (at[i] == k);
                er[i] = !rising && (at[i] == k);
                el[i] = (at[i] != 0 && k >= at[i]) ? ~lv0[i] : lv0[i];
            end
            chk($sformatf("%s_press_k%0d", tag, k), btn_press, ep);
            chk($sformatf("%s_release_k%0d", tag, k), btn_release, er);
            chk($sformatf("%s_level_k%0d", tag, k), btn_level, el);
        end
    endtask

    initial begin
        logic [1:0] ep, er, el;

        // 1. Reset with both buttons held, then fresh press after release of reset.
        rst     = 1'b1;
        btn_raw = 2'b11;
        window("reset", 3, 0, 0, 2'b00, 1'b1);
        rst = 1'b0;
        window("rst_rel", 9, 7, 7, 2'b00, 1'b1);
        btn_raw = 2'b00;
        window("rel_both", 9, 7, 7, 2'b11, 1'b0);

        // 2. Single press and release on channel 0.
        btn_raw = 2'b01;
        window("p0", 9, 7, 0, 2'b00, 1'b1);
        btn_raw = 2'b00;
        window("r0", 9, 7, 0, 2'b01, 1'b0);

        // 3. Bounce on channel 1: short pulse rejected, then a glitch restarts the count.
        btn_raw = 2'b10;
        window("bnc_hi", 3, 0, 0, 2'b00, 1'b1);
        btn_raw = 2'b00;
        window("bnc_lo", 8, 0, 0, 2'b00, 1'b1);
        btn_raw = 2'b10;
        window("b2_hi", 3, 0, 0, 2'b00, 1'b1);
        btn_raw = 2'b00;
        window("b2_gap", 1, 0, 0, 2'b00, 1'b1);
        btn_raw = 2'b10;
        window("b2_press", 9, 0, 7, 2'b00, 1'b1);
        btn_raw = 2'b00;
        window("b2_rel", 9, 0, 7, 2'b10, 1'b0);

        // 4. Both channels pressed two cycles apart.
        btn_raw = 2'b01;
        window("stag_a", 2, 0, 0, 2'b00, 1'b1);
        btn_raw = 2'b11;
        window("stag_b", 8, 5, 7, 2'b00, 1'b1);

        // 5. Reset while both levels are high: cleared next edge, no release afterwards.
        rst     = 1'b1;
        btn_raw = 2'b00;
        window("rst_mid", 2, 0, 0, 2'b00, 1'b1);
        rst = 1'b0;
        window("post_rst", 10, 0, 0, 2'b00, 1'b1);

        // 6. Long hold on channel 0, released after edge 30 (sampled at edge 31).
        btn_raw = 2'b01;
        for (int k = 1; k <= 44; k++) begin
            cyc();
            ep = 2'b00;
            er = 2'b00;
            el = 2'b00;
            ep[0] = (k == 7) || (AR && k >= 17 && k <= 32 && ((k - 17) % 3) == 0);
            er[0] = (k == 37);
            el[0] = (k >= 7) && (k < 37);
            chk($sformatf("hold_press_k%0d", k), btn_press, ep);
            chk($sformatf("hold_release_k%0d", k), btn_release, er);
            chk($sformatf("hold_level_k%0d", k), btn_level, el);
            if (k == 30) btn_raw = 2'b00;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
